// File: rtl/amp_phase_cal_ctrl.sv
// Calibration sequencer: averages reference and tone measurements, loads them into the
// correction datapath, waits for it to settle, then gates one frame of QPSK samples.
// IDLE 0 | ACQ_REF 1 ref avg | ACQ_TONE 2 tone avg | LOAD 3 | WAIT_RDY 4 | RUN 5 | DONE 6 | ERR 7 timeout
module amp_phase_cal_ctrl #(
  parameter int AVG_LOG2  = 3,
  parameter int DIV_LAT   = 30,
  parameter int TIMEOUT   = 65535,
  parameter int FRAME_LEN = 80000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cal_start,
  input  logic signed [11:0] ref_meas_phase,
  input  logic signed [11:0] ref_meas_amp,
  input  logic               ref_meas_valid,
  input  logic signed [11:0] tone_meas_phase,
  input  logic signed [11:0] tone_meas_amp,
  input  logic               tone_meas_valid,
  input  logic               corr_ready,
  input  logic               qpsk_in_valid,
  input  logic               qpsk_out_valid,
  output logic signed [11:0] ref_phase,
  output logic signed [11:0] ref_amplitude,
  output logic               ref_valid,
  output logic signed [11:0] channel_phase,
  output logic signed [11:0] channel_amplitude,
  output logic               channel_data_valid,
  output logic               qpsk_gated_valid,
  output logic [16:0]        out_count,
  output logic               cal_busy,
  output logic               frame_done,
  output logic               cal_err,
  output logic [2:0]         state
);
  typedef enum logic [2:0] {
    IDLE = 3'd0, ACQ_REF = 3'd1, ACQ_TONE = 3'd2, LOAD = 3'd3,
    WAIT_RDY = 3'd4, RUN = 3'd5, DONE = 3'd6, ERR = 3'd7
  } state_t;

  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DIV_LAT + 1) + 1;
  localparam logic [CW-1:0] LAST_SMP  = CW'((1 << AVG_LOG2) - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DIV_INIT  = DW'(DIV_LAT);
  localparam logic [16:0]   FRAME_END = 17'(FRAME_LEN);

  state_t               state_q;
  logic signed [AW-1:0] ref_ph_acc_q, ref_amp_acc_q, tone_ph_acc_q, tone_amp_acc_q;
  logic signed [AW-1:0] ref_ph_sum, ref_amp_sum, tone_ph_sum, tone_amp_sum;
  logic [CW-1:0]        smp_cnt_q;
  logic [WW-1:0]        wait_q;
  logic [DW-1:0]        div_q;
  logic                 load_last_q;
  logic [16:0]          out_cnt_q, out_cnt_inc;
  logic signed [11:0]   ref_phase_q, ref_amp_q, chan_phase_q, chan_amp_q;
  logic                 ref_valid_q, chan_valid_q, frame_done_q, cal_err_q, cal_busy_q;

  assign ref_ph_sum   = ref_ph_acc_q + AW'(ref_meas_phase);
  assign ref_amp_sum  = ref_amp_acc_q + AW'(ref_meas_amp);
  assign tone_ph_sum  = tone_ph_acc_q + AW'(tone_meas_phase);
  assign tone_amp_sum = tone_amp_acc_q + AW'(tone_meas_amp);
  assign out_cnt_inc  = out_cnt_q + 17'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ref_ph_acc_q   <= '0;
      ref_amp_acc_q  <= '0;
      tone_ph_acc_q  <= '0;
      tone_amp_acc_q <= '0;
      smp_cnt_q      <= '0;
      wait_q         <= '0;
      div_q          <= '0;
      load_last_q    <= 1'b0;
      out_cnt_q      <= '0;
      ref_phase_q    <= '0;
      ref_amp_q      <= '0;
      chan_phase_q   <= '0;
      chan_amp_q     <= '0;
      ref_valid_q    <= 1'b0;
      chan_valid_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      cal_err_q      <= 1'b0;
      cal_busy_q     <= 1'b0;
    end else begin
      ref_valid_q  <= 1'b0;
      chan_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (cal_start) begin
            state_q        <= ACQ_REF;
            ref_ph_acc_q   <= '0;
            ref_amp_acc_q  <= '0;
            tone_ph_acc_q  <= '0;
            tone_amp_acc_q <= '0;
            smp_cnt_q      <= '0;
            wait_q         <= WAIT_INIT;
            out_cnt_q      <= '0;
            cal_err_q      <= 1'b0;
            cal_busy_q     <= 1'b1;
          end
        end
        ACQ_REF: begin
          if (ref_meas_valid) begin
            ref_ph_acc_q  <= ref_ph_sum;
            ref_amp_acc_q <= ref_amp_sum;
            wait_q        <= WAIT_INIT;
            if (smp_cnt_q == LAST_SMP) begin
              smp_cnt_q <= '0;
              state_q   <= ACQ_TONE;
            end else begin
              smp_cnt_q <= smp_cnt_q + CW'(1);
            end
          end else if (wait_q == '0) begin
            state_q    <= ERR;
            cal_err_q  <= 1'b1;
            cal_busy_q <= 1'b0;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        ACQ_TONE: begin
          if (tone_meas_valid) begin
            tone_ph_acc_q  <= tone_ph_sum;
            tone_amp_acc_q <= tone_amp_sum;
            wait_q         <= WAIT_INIT;
            if (smp_cnt_q == LAST_SMP) begin
              // Averages are taken from the completed sums, so the last sample counts.
              smp_cnt_q    <= '0;
              state_q      <= LOAD;
              load_last_q  <= 1'b0;
              ref_valid_q  <= 1'b1;
              chan_valid_q <= 1'b1;
              ref_phase_q  <= 12'(ref_ph_acc_q >>> AVG_LOG2);
              ref_amp_q    <= 12'(ref_amp_acc_q >>> AVG_LOG2);
              chan_phase_q <= 12'(tone_ph_sum >>> AVG_LOG2);
              chan_amp_q   <= 12'(tone_amp_sum >>> AVG_LOG2);
            end else begin
              smp_cnt_q <= smp_cnt_q + CW'(1);
            end
          end else if (wait_q == '0) begin
            state_q    <= ERR;
            cal_err_q  <= 1'b1;
            cal_busy_q <= 1'b0;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        LOAD: begin
          if (!load_last_q) begin
            load_last_q  <= 1'b1;
            ref_valid_q  <= 1'b1;
            chan_valid_q <= 1'b1;
          end else begin
            state_q <= WAIT_RDY;
            wait_q  <= WAIT_INIT;
            div_q   <= DIV_INIT;
          end
        end
        WAIT_RDY: begin
          if (div_q != '0) div_q <= div_q - DW'(1);
          if (div_q == '0 && corr_ready) begin
            state_q    <= RUN;
            cal_busy_q <= 1'b0;
          end else if (wait_q == '0) begin
            state_q    <= ERR;
            cal_err_q  <= 1'b1;
            cal_busy_q <= 1'b0;
          end else begin
            wait_q <= wait_q - WW'(1);
          end
        end
        RUN: begin
          if (qpsk_out_valid) begin
            out_cnt_q <= out_cnt_inc;
            if (out_cnt_inc >= FRAME_END) begin
              state_q      <= DONE;
              frame_done_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign qpsk_gated_valid   = (state_q == RUN) && qpsk_in_valid;
  assign ref_phase          = ref_phase_q;
  assign ref_amplitude      = ref_amp_q;
  assign ref_valid          = ref_valid_q;
  assign channel_phase      = chan_phase_q;
  assign channel_amplitude  = chan_amp_q;
  assign channel_data_valid = chan_valid_q;
  assign out_count          = out_cnt_q;
  assign cal_busy           = cal_busy_q;
  assign frame_done         = frame_done_q;
  assign cal_err            = cal_err_q;
  assign state              = state_q;
endmodule

// File: tb/tb_amp_phase_cal_ctrl.sv
// Bench for amp_phase_cal_ctrl: table vectors for averaging, random calibrations against a
// floor-division model, plus hand sequences for timeouts, ignored starts and mid-LOAD reset.
module tb_amp_phase_cal_ctrl;
  localparam int DIV_LAT   = 6;
  localparam int TIMEOUT   = 100;
  localparam int FRAME_LEN = 16;

  logic               clk = 1'b0;
  logic               rst, cal_start, ref_meas_valid, tone_meas_valid;
  logic               corr_ready, qpsk_in_valid, qpsk_out_valid;
  logic signed [11:0] ref_meas_phase, ref_meas_amp, tone_meas_phase, tone_meas_amp;
  logic signed [11:0] ref_phase, ref_amplitude, channel_phase, channel_amplitude;
  logic               ref_valid, channel_data_valid, qpsk_gated_valid;
  logic [16:0]        out_count;
  logic               cal_busy, frame_done, cal_err;
  logic [2:0]         state;

  int n_cmp = 0;
  int n_mis = 0;
  int sra[8], srp[8], sta[8], stp[8];

  typedef struct {
    int ra0, ra1, rp0, rp1, ta0, ta1, tp0, tp1;
    int e_ra, e_rp, e_ta, e_tp;
  } vec_t;
  vec_t vt[4];

  amp_phase_cal_ctrl #(.AVG_LOG2(3), .DIV_LAT(DIV_LAT), .TIMEOUT(TIMEOUT), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start),
    .ref_meas_phase(ref_meas_phase), .ref_meas_amp(ref_meas_amp), .ref_meas_valid(ref_meas_valid),
    .tone_meas_phase(tone_meas_phase), .tone_meas_amp(tone_meas_amp), .tone_meas_valid(tone_meas_valid),
    .corr_ready(corr_ready), .qpsk_in_valid(qpsk_in_valid), .qpsk_out_valid(qpsk_out_valid),
    .ref_phase(ref_phase), .ref_amplitude(ref_amplitude), .ref_valid(ref_valid),
    .channel_phase(channel_phase), .channel_amplitude(channel_amplitude),
    .channel_data_valid(channel_data_valid), .qpsk_gated_valid(qpsk_gated_valid),
    .out_count(out_count), .cal_busy(cal_busy), .frame_done(frame_done), .cal_err(cal_err),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Mean of eight samples rounded toward minus infinity.
  function automatic int favg(input int v[8]);
    int s = 0;
    for (int i = 0; i < 8; i++) s += v[i];
    return (s >= 0) ? s / 8 : -((-s + 7) / 8);
  endfunction

  task automatic put_ref(input int a, input int p);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      ref_meas_valid  = 1'b0;
      tone_meas_valid = 1'($urandom_range(0, 1));
      tone_meas_amp   = 12'($urandom);
      tone_meas_phase = 12'($urandom);
      qpsk_out_valid  = 1'($urandom_range(0, 1));
      qpsk_in_valid   = 1'b1;
      #1 chk("gated_acq", qpsk_gated_valid, 0);
      tick();
    end
    ref_meas_valid  = 1'b1;
    ref_meas_amp    = 12'(a);
    ref_meas_phase  = 12'(p);
    tone_meas_valid = 1'b0;
    tick();
    ref_meas_valid = 1'b0;
  endtask

  task automatic put_tone(input int a, input int p);
    int g;
    g = $urandom_range(0, 2);
    repeat (g) begin
      tone_meas_valid = 1'b0;
      ref_meas_valid  = 1'($urandom_range(0, 1));
      ref_meas_amp    = 12'($urandom);
      ref_meas_phase  = 12'($urandom);
      qpsk_out_valid  = 1'($urandom_range(0, 1));
      tick();
    end
    tone_meas_valid = 1'b1;
    tone_meas_amp   = 12'(a);
    tone_meas_phase = 12'(p);
    ref_meas_valid  = 1'b0;
    tick();
    tone_meas_valid = 1'b0;
  endtask

  task automatic acquire();
    for (int i = 0; i < 8; i++) put_ref(sra[i], srp[i]);
    for (int i = 0; i < 8; i++) put_tone(sta[i], stp[i]);
    qpsk_out_valid = 1'b0;
    qpsk_in_valid  = 1'b0;
  endtask

  task automatic start_cal();
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    chk("start_state", state, 1);
    chk("start_busy", cal_busy, 1);
    chk("start_err_clear", cal_err, 0);
  endtask

  task automatic check_load(input int ea, input int ep, input int ca, input int cp);
    chk("load1_state", state, 3);
    chk("load1_ref_valid", ref_valid, 1);
    chk("load1_ch_valid", channel_data_valid, 1);
    chk("ref_amplitude", ref_amplitude, ea);
    chk("ref_phase", ref_phase, ep);
    chk("channel_amplitude", channel_amplitude, ca);
    chk("channel_phase", channel_phase, cp);
    corr_ready = 1'b0;
    tick();
    chk("load2_state", state, 3);
    chk("load2_ref_valid", ref_valid, 1);
    chk("load2_ch_valid", channel_data_valid, 1);
    tick();
    chk("wait_state", state, 4);
    chk("wait_ref_valid", ref_valid, 0);
    chk("wait_ch_valid", channel_data_valid, 0);
  endtask

  task automatic enter_run(input int dly);
    int n, lim;
    bit got;
    lim = ((dly > DIV_LAT) ? dly : DIV_LAT) + 1;
    n = 0;
    got = 1'b0;
    chk("wait_busy", cal_busy, 1);
    while (!got && n < 300) begin
      corr_ready = (n >= dly);
      tick();
      n++;
      got = (state == 3'd5);
    end
    chk("run_entry_latency", n, lim);
    chk("run_busy", cal_busy, 0);
    chk("run_out_count", out_count, 0);
  endtask

  task automatic frame(input bit cont, input bit poke);
    int cnt, k;
    bit done;
    cnt = 0;
    k = 0;
    done = 1'b0;
    while (!done && k < 200) begin
      qpsk_in_valid  = 1'($urandom_range(0, 1));
      qpsk_out_valid = cont ? 1'b1 : ($urandom_range(0, 3) != 0);
      cal_start      = poke && (k == 2);
      #1 chk("gated_run", qpsk_gated_valid, qpsk_in_valid);
      if (qpsk_out_valid) cnt++;
      tick();
      k++;
      cal_start = 1'b0;
      if (cnt >= FRAME_LEN) begin
        chk("done_state", state, 6);
        chk("frame_done_pulse", frame_done, 1);
        chk("final_count", out_count, FRAME_LEN);
        done = 1'b1;
      end else begin
        chk("run_state", state, 5);
        chk("run_count", out_count, cnt);
        chk("frame_done_low", frame_done, 0);
      end
    end
    chk("frame_completed", done, 1);
    qpsk_in_valid  = 1'b1;
    qpsk_out_valid = 1'b1;
    #1 chk("gated_done", qpsk_gated_valid, 0);
    tick();
    chk("frame_done_cleared", frame_done, 0);
    chk("count_held_done", out_count, FRAME_LEN);
    chk("done_held", state, 6);
    qpsk_in_valid  = 1'b0;
    qpsk_out_valid = 1'b0;
  endtask

  task automatic wait_timeout(input int ea);
    repeat (TIMEOUT - 1) tick();
    chk("wait_before_timeout", state, 4);
    tick();
    chk("wait_timeout_state", state, 7);
    chk("wait_timeout_err", cal_err, 1);
    chk("err_busy", cal_busy, 0);
    chk("err_hold_ref_amp", ref_amplitude, ea);
  endtask

  initial begin
    int strobes;
    rst = 1'b1; cal_start = 1'b0; corr_ready = 1'b0;
    ref_meas_valid = 1'b0; tone_meas_valid = 1'b0;
    ref_meas_amp = '0; ref_meas_phase = '0; tone_meas_amp = '0; tone_meas_phase = '0;
    qpsk_in_valid = 1'b1; qpsk_out_valid = 1'b0;

    vt[0] = '{100, 100, 64, 64, 80, 80, 32, 32, 100, 64, 80, 32};
    vt[1] = '{10, 10, 0, 0, 5, 5, -3, 2, 10, 0, 5, -1};
    vt[2] = '{-2048, -2048, 2047, 2047, -1, 0, 1, 2, -2048, 2047, -1, 1};
    vt[3] = '{-5, -6, 7, -8, 2047, 2046, -2048, -2047, -6, -1, 2046, -2048};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_ref_valid", ref_valid, 0);
    chk("rst_ch_valid", channel_data_valid, 0);
    chk("rst_ref_phase", ref_phase, 0);
    chk("rst_ref_amp", ref_amplitude, 0);
    chk("rst_ch_phase", channel_phase, 0);
    chk("rst_ch_amp", channel_amplitude, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_busy", cal_busy, 0);
    chk("rst_err", cal_err, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_gated", qpsk_gated_valid, 0);
    qpsk_in_valid = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8; k++) begin
        sra[k] = (k % 2 == 0) ? vt[i].ra0 : vt[i].ra1;
        srp[k] = (k % 2 == 0) ? vt[i].rp0 : vt[i].rp1;
        sta[k] = (k % 2 == 0) ? vt[i].ta0 : vt[i].ta1;
        stp[k] = (k % 2 == 0) ? vt[i].tp0 : vt[i].tp1;
      end
      start_cal();
      acquire();
      check_load(vt[i].e_ra, vt[i].e_rp, vt[i].e_ta, vt[i].e_tp);
      if (i % 2 == 0) begin
        enter_run((i == 0) ? 0 : 9);
        frame(1'b0, 1'b0);
      end else begin
        wait_timeout(vt[i].e_ra);
      end
      chk("hold_ref_amp", ref_amplitude, vt[i].e_ra);
      chk("hold_ch_phase", channel_phase, vt[i].e_tp);
    end

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 8; k++) begin
        sra[k] = int'($urandom_range(0, 4095)) - 2048;
        srp[k] = int'($urandom_range(0, 4095)) - 2048;
        sta[k] = int'($urandom_range(0, 4095)) - 2048;
        stp[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      start_cal();
      acquire();
      check_load(favg(sra), favg(srp), favg(sta), favg(stp));
      enter_run($urandom_range(0, 12));
      frame(r == 0, 1'b0);
    end

    // Reference measurements never arrive: timeout into ERR without load strobes.
    start_cal();
    strobes = 0;
    repeat (TIMEOUT - 1) begin
      tick();
      if (ref_valid || channel_data_valid) strobes++;
    end
    chk("acq_before_timeout", state, 1);
    tick();
    chk("acq_timeout_state", state, 7);
    chk("acq_timeout_err", cal_err, 1);
    chk("acq_timeout_strobes", strobes, 0);

    // cal_start mid-acquisition must not restart averaging.
    start_cal();
    for (int i = 0; i < 4; i++) put_ref(50, -10);
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    for (int i = 0; i < 4; i++) put_ref(50, -10);
    chk("ignored_start_state", state, 2);
    for (int i = 0; i < 8; i++) put_tone(20, 5);
    qpsk_out_valid = 1'b0;
    qpsk_in_valid  = 1'b0;
    chk("mid_load_state", state, 3);
    chk("mid_load_ref_amp", ref_amplitude, 50);
    chk("mid_load_ch_phase", channel_phase, 5);

    // Reset in the first LOAD cycle abandons the calibration at once.
    rst = 1'b1;
    #1;
    chk("rst_load_ref_valid", ref_valid, 0);
    chk("rst_load_ch_valid", channel_data_valid, 0);
    chk("rst_load_state", state, 0);
    chk("rst_load_ref_amp", ref_amplitude, 0);
    tick();
    tick();
    rst = 1'b0;
    strobes = 0;
    repeat (4) begin
      tick();
      if (ref_valid || channel_data_valid || state != 3'd0) strobes++;
    end
    chk("post_rst_quiet", strobes, 0);

    for (int k = 0; k < 8; k++) begin
      sra[k] = 100; srp[k] = 64; sta[k] = 80; stp[k] = 32;
    end
    start_cal();
    acquire();
    check_load(100, 64, 80, 32);
    enter_run(0);
    frame(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/amp_phase_cal_ctrl.md
AMP_PHASE_CAL_CTRL -- requirements
Module: amp_phase_cal_ctrl

Interface
REQ-001 Parameters: AVG_LOG2, default 3, log2 of the number of averaged measurements (N=8); DIV_LAT, default 30, minimum WAIT_RDY dwell in cycles; TIMEOUT, default 65535, maximum cycles in any waiting state; FRAME_LEN, default 80000, corrected samples per frame.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cal_start  in  1  calibration request pulse
- ref_meas_phase  in  12  signed fix12_8 reference phase measurement
- ref_meas_amp  in  12  signed reference amplitude measurement
- ref_meas_valid  in  1  reference measurement strobe
- tone_meas_phase  in  12  signed fix12_8 channel tone phase
- tone_meas_amp  in  12  signed channel tone amplitude
- tone_meas_valid  in  1  tone measurement strobe
- corr_ready  in  1  correction datapath ready (sticky once set)
- qpsk_in_valid  in  1  upstream QPSK sample valid
- qpsk_out_valid  in  1  corrected-sample valid from datapath
- ref_phase  out  12  averaged reference phase
- ref_amplitude  out  12  averaged reference amplitude
- ref_valid  out  1  reference load strobe
- channel_phase  out  12  averaged tone phase
- channel_amplitude  out  12  averaged tone amplitude
- channel_data_valid  out  1  channel load strobe
- qpsk_gated_valid  out  1  qpsk_in_valid gated by RUN
- out_count  out  17  corrected samples counted this frame
- cal_busy  out  1  high in ACQ_REF..WAIT_RDY
- frame_done  out  1  one-cycle pulse at end of frame
- cal_err  out  1  sticky timeout flag
- state  out  3  current FSM state encoding

Function
REQ-004 FSM states SHALL be IDLE=0, ACQ_REF=1, ACQ_TONE=2, LOAD=3, WAIT_RDY=4, RUN=5, DONE=6, ERR=7.
REQ-005 cal_start SHALL be honoured only in IDLE, DONE or ERR (next state ACQ_REF, clears accumulators, counters, cal_err); it SHALL be ignored in all other states.
REQ-006 ACQ_REF SHALL accumulate 2^AVG_LOG2 ref_meas_valid samples into (12+AVG_LOG2)-bit signed accumulators, then go to ACQ_TONE; tone_meas_valid in ACQ_REF SHALL be ignored.
REQ-007 ACQ_TONE SHALL accumulate 2^AVG_LOG2 tone_meas_valid samples likewise, then go to LOAD; ref_meas_valid in ACQ_TONE SHALL be ignored.
REQ-008 Averages SHALL be accumulator arithmetic-shifted right by AVG_LOG2 (round toward minus infinity), registered on output ports and held stable outside reset/cal_start.
REQ-009 LOAD SHALL last exactly 2 cycles with ref_valid and channel_data_valid both high on both cycles, so the datapath's registered phase difference and wrapped rotation both capture the new values; then go to WAIT_RDY.
REQ-010 WAIT_RDY SHALL ignore corr_ready for the first DIV_LAT cycles, then go to RUN on the first cycle corr_ready=1.
REQ-011 A wait counter SHALL reset on entry to ACQ_REF, ACQ_TONE and WAIT_RDY and on each accepted measurement; reaching TIMEOUT SHALL go to ERR and set cal_err.
REQ-012 qpsk_gated_valid SHALL equal qpsk_in_valid combinationally in RUN and be 0 otherwise.
REQ-013 In RUN out_count SHALL increment on qpsk_out_valid; when it reaches FRAME_LEN, frame_done SHALL pulse the same cycle the FSM enters DONE; out_count SHALL saturate at FRAME_LEN.
REQ-014 qpsk_out_valid outside RUN SHALL NOT change out_count.
REQ-015 DONE and ERR SHALL hold all outputs except strobes, which are 0.

Reset
REQ-016 While rst=1: state=IDLE, all strobes 0, all data outputs 0, out_count=0, cal_err=0, cal_busy=0, accumulators and counters cleared; reset mid-operation SHALL abandon the calibration with no further strobes.

Verification
REQ-017 cal_start; 8 ref samples 100 (phase 64), 8 tone samples 80 (phase 32) -> two-cycle LOAD with ref_amplitude=100, ref_phase=64, channel_amplitude=80, channel_phase=32.
REQ-018 Tone phases alternating -3/+2 for 8 samples -> channel_phase=-1 (floor of -4/8).
REQ-019 corr_ready held 1 from start -> RUN entered exactly DIV_LAT+1 cycles after LOAD ends.
REQ-020 ref_meas_valid absent for TIMEOUT cycles in ACQ_REF -> state=ERR, cal_err=1, no load strobes; later cal_start clears cal_err.
REQ-021 FRAME_LEN=16, continuous qpsk_out_valid in RUN -> frame_done pulse with out_count=16, state=DONE, qpsk_gated_valid=0 afterwards.
REQ-022 rst asserted during LOAD first cycle -> strobes drop immediately, state=IDLE, cal_start in RUN ignored.
